// File: rtl/bus_arbiter_2m.sv
// Two-master shared-bus controller: round-robin grant FSM with bounded tenure,
// shared address/write/data mux, page decode into two slave selects, and read return.
module bus_arbiter_2m #(
  parameter logic [7:0] S0_PAGE  = 8'h00,
  parameter logic [7:0] S1_PAGE  = 8'h07,
  parameter int         MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_wr,
  input  logic        m1_wr,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m1_addr,
  input  logic [31:0] m0_dout,
  input  logic [31:0] m1_dout,
  input  logic [31:0] s0_dout,
  input  logic [31:0] s1_dout,
  output logic        m0_grant,
  output logic        m1_grant,
  output logic        s_sel0,
  output logic        s_sel1,
  output logic [15:0] s_addr,
  output logic        s_wr,
  output logic [31:0] s_din,
  output logic [31:0] m_din
);

  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                last_q, last_d;
  logic [1:0]          sel_q;
  logic                granted;
  logic                page0_hit;
  logic                page1_hit;

  // Arbitration: next grant, tenure count and round-robin pointer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req && m1_req) state_d = last_q ? G0 : G1;
        else if (m0_req)      state_d = G0;
        else if (m1_req)      state_d = G1;
      end
      G0: begin
        if (!m0_req)                           state_d = m1_req ? G1 : IDLE;
        else if (m1_req && hold_q == HOLD_LAST) state_d = G1;
      end
      G1: begin
        if (!m1_req)                           state_d = m0_req ? G0 : IDLE;
        else if (m0_req && hold_q == HOLD_LAST) state_d = G0;
      end
      default: state_d = IDLE;
    endcase

    // Saturating at HOLD_LAST lets an uncontested owner keep the bus while a
    // newly arriving requester still gets it on the very next edge.
    hold_d = hold_q;
    if (state_d != state_q)                          hold_d = '0;
    else if (state_q != IDLE && hold_q != HOLD_LAST) hold_d = hold_q + 1'b1;

    last_d = last_q;
    if (state_d == G0)      last_d = 1'b0;
    else if (state_d == G1) last_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
      sel_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      sel_q   <= {s_sel1, s_sel0};
    end
  end

  // Shared bus drive and decode, combinational from the grant state
  always_comb begin
    m0_grant = (state_q == G0);
    m1_grant = (state_q == G1);
    granted  = m0_grant | m1_grant;
    s_addr   = 16'h0000;
    s_wr     = 1'b0;
    s_din    = 32'h0000_0000;
    if (m0_grant) begin
      s_addr = m0_addr;
      s_wr   = m0_wr;
      s_din  = m0_dout;
    end else if (m1_grant) begin
      s_addr = m1_addr;
      s_wr   = m1_wr;
      s_din  = m1_dout;
    end
    page0_hit = (s_addr[15:8] == S0_PAGE);
    page1_hit = (s_addr[15:8] == S1_PAGE);
    s_sel0    = granted & page0_hit;
    s_sel1    = granted & page1_hit & ~page0_hit;
  end

  // Read return follows the select of the previous cycle
  always_comb begin
    unique case (sel_q)
      2'b01:   m_din = s0_dout;
      2'b10:   m_din = s1_dout;
      default: m_din = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Scoreboard bench for bus_arbiter_2m: directed scenarios plus randomized traffic,
// checked against an ownership/tenure model of the arbitration rules.
module tb_bus_arbiter_2m;

  localparam int MAX_HOLD = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic        m0_wr = 1'b0, m1_wr = 1'b0;
  logic [15:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_dout = '0, m1_dout = '0;
  logic [31:0] s0_dout = '0, s1_dout = '0;
  logic        m0_grant, m1_grant, s_sel0, s_sel1, s_wr;
  logic [15:0] s_addr;
  logic [31:0] s_din, m_din;

  bus_arbiter_2m #(.S0_PAGE(8'h00), .S1_PAGE(8'h07), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_dout(m0_dout), .m1_dout(m1_dout),
    .s0_dout(s0_dout), .s1_dout(s1_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant), .s_sel0(s_sel0), .s_sel1(s_sel1),
    .s_addr(s_addr), .s_wr(s_wr), .s_din(s_din), .m_din(m_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        g0, g1, sel0, sel1, wr;
    logic [15:0] addr;
    logic [31:0] din, mdin;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: current owner (-1 none), cycles owned so far, last winner,
  // and which slave was addressed in the previous cycle (0 none, 1 s0, 2 s1).
  int owner = -1;
  int held = 0;
  int last = 1;
  int prev_sel = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_owner(input bit r0, input bit r1);
    bit own_rq, oth_rq;
    if (owner < 0) begin
      if (r0 && r1) return 1 - last;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
    end
    own_rq = (owner == 0) ? r0 : r1;
    oth_rq = (owner == 0) ? r1 : r0;
    if (!own_rq) return oth_rq ? 1 - owner : -1;
    if (oth_rq && held >= MAX_HOLD) return 1 - owner;
    return owner;
  endfunction

  function automatic void model_reset();
    owner = -1; held = 0; last = 1; prev_sel = 0;
  endfunction

  // Drive one cycle of inputs and push the outputs the model expects for it.
  task automatic cycle(input bit rs, input bit r0, input bit r1, input bit w0, input bit w1,
                       input logic [15:0] a0, input logic [15:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] sd0, input logic [31:0] sd1);
    exp_t e;
    int nxt;
    logic [7:0] pg;
    @(posedge clk); #1;
    reset = rs; m0_req = r0; m1_req = r1; m0_wr = w0; m1_wr = w1;
    m0_addr = a0; m1_addr = a1; m0_dout = d0; m1_dout = d1; s0_dout = sd0; s1_dout = sd1;
    e = '{default: 0};
    if (rs) begin
      model_reset();
    end else begin
      e.g0   = (owner == 0);
      e.g1   = (owner == 1);
      e.addr = (owner == 0) ? a0 : (owner == 1) ? a1 : 16'h0;
      e.wr   = (owner == 0) ? w0 : (owner == 1) ? w1 : 1'b0;
      e.din  = (owner == 0) ? d0 : (owner == 1) ? d1 : 32'h0;
      pg     = e.addr[15:8];
      e.sel0 = (owner >= 0) && (pg == 8'h00);
      e.sel1 = (owner >= 0) && (pg == 8'h07) && !e.sel0;
      e.mdin = (prev_sel == 1) ? sd0 : (prev_sel == 2) ? sd1 : 32'h0;
      prev_sel = e.sel0 ? 1 : e.sel1 ? 2 : 0;
      nxt = next_owner(r0, r1);
      if (nxt != owner) held = (nxt < 0) ? 0 : 1;
      else if (owner >= 0) held++;
      if (nxt >= 0) last = nxt;
      owner = nxt;
    end
    sb.push_back(e);
  endtask

  function automatic logic [15:0] rnd_addr();
    logic [7:0] lo;
    lo = 8'($urandom_range(0, 255));
    case ($urandom_range(0, 3))
      0: return {8'h00, lo};
      1: return {8'h07, lo};
      2: return {8'h30, lo};
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  task automatic rcyc(input bit r0, input bit r1);
    cycle(1'b0, r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          rnd_addr(), rnd_addr(), $urandom(), $urandom(), $urandom(), $urandom());
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_g0"}, m0_grant, 0);
    chk({tag, "_g1"}, m1_grant, 0);
    chk({tag, "_sel0"}, s_sel0, 0);
    chk({tag, "_sel1"}, s_sel1, 0);
    chk({tag, "_swr"}, s_wr, 0);
    chk({tag, "_saddr"}, s_addr, 0);
    chk({tag, "_sdin"}, s_din, 0);
    chk({tag, "_mdin"}, m_din, 0);
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("m0_grant", m0_grant, e.g0);
        chk("m1_grant", m1_grant, e.g1);
        chk("s_sel0", s_sel0, e.sel0);
        chk("s_sel1", s_sel1, e.sel1);
        chk("s_addr", s_addr, e.addr);
        chk("s_wr", s_wr, e.wr);
        chk("s_din", s_din, e.din);
        chk("m_din", m_din, e.mdin);
      end
    end
  end

  initial begin
    bit q0, q1;
    #2;
    check_all_zero("reset_state");
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Single m0 request
    for (int i = 0; i < 4; i++)
      cycle(0, 1, 0, 0, 0, 16'h0100 + 16'(i), 16'h0700, 32'hA0 + 32'(i), 32'hB0, 32'h5, 32'h6);
    rcyc(0, 0); rcyc(0, 0);
    // Both requesting: alternating tenures of MAX_HOLD cycles
    for (int i = 0; i < 3 * MAX_HOLD + 4; i++) rcyc(1, 1);
    rcyc(0, 0); rcyc(0, 0);
    // m0 read from slave 1 page, then idle
    for (int i = 0; i < 3; i++)
      cycle(0, 1, 0, 0, 0, 16'h0704, 16'h0000, 32'h0, 32'h0, 32'h1111_0000, 32'hCAFE_0001);
    for (int i = 0; i < 3; i++)
      cycle(0, 0, 0, 0, 0, 16'h0704, 16'h0000, 32'h0, 32'h0, 32'h1111_0000, 32'hCAFE_0001);
    // m1 write to slave 0, then to an unmapped address
    for (int i = 0; i < 3; i++)
      cycle(0, 0, 1, 0, 1, 16'h0000, 16'h0010, 32'h0, 32'h1234_5678, 32'h9, 32'hA);
    for (int i = 0; i < 2; i++)
      cycle(0, 0, 1, 0, 1, 16'h0000, 16'h3000, 32'h0, 32'h1234_5678, 32'h9, 32'hA);
    rcyc(0, 0); rcyc(0, 0);
    // m0 drops while m1 waits; m1 then gets a full fresh tenure
    for (int i = 0; i < 3; i++) rcyc(1, 0);
    for (int i = 0; i < 3; i++) rcyc(1, 1);
    for (int i = 0; i < 2; i++) rcyc(0, 1);
    for (int i = 0; i < MAX_HOLD + 6; i++) rcyc(1, 1);
    rcyc(0, 0); rcyc(0, 0);
    // Asynchronous reset in the middle of an m1 tenure
    for (int i = 0; i < 4; i++) rcyc(0, 1);
    @(negedge clk); #1;
    reset = 1'b1;
    model_reset();
    #1;
    check_all_zero("async_reset");
    cycle(1, 1, 1, 0, 0, 16'h0010, 16'h0020, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 16'h0010, 16'h0020, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) rcyc(1, 1);
    // Randomized traffic with sticky requests and occasional resets
    q0 = 0; q1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) q0 = ~q0;
      if ($urandom_range(0, 7) == 0) q1 = ~q1;
      if ($urandom_range(0, 499) == 0)
        cycle(1, q0, q1, 0, 0, rnd_addr(), rnd_addr(), $urandom(), $urandom(), $urandom(), $urandom());
      else
        rcyc(q0, q1);
    end
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
